shiftreg_seq: RTL and testbench

// Sequencer for the latch-based serial shift register (DL_shiftreg-style sink: si, clk -> po, so).
// - Accepts a parallel word over valid/ready and shifts it in, one bit per generated clock pulse, on sr_si/sr_clk.
// - Reads the word back from sr_po/sr_so and returns it with a loopback-mismatch flag.
// - Owns all setup, pulse and settle timing of the gate-delay register so upstream logic stays synchronous.

---
 rtl/shiftreg_seq.sv | 161 ++++++++++++++++
 tb/tb_shiftreg_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_seq.sv
// Sequencer for a latch-based serial shift register sink: shifts a parallel word in one
// generated pulse per bit, then reads it back through sr_po/sr_so and flags any loopback mismatch.
module shiftreg_seq #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_si,
  output logic             sr_clk,
  input  logic [WIDTH-2:0] sr_po,
  input  logic             sr_so,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int CW  = $clog2(WIDTH);
  localparam int SW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int SLD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic              sr_clk_q, sr_clk_d;
  logic              sr_si_q, sr_si_d;
  logic              end_of_bit;
  logic [WIDTH-1:0]  readback_w;

  // Serial bit k of a word, in transmission order.
  function automatic logic bit_of(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == k) begin
        b = (MSB_FIRST != 0) ? w[WIDTH-1-i] : w[i];
      end
    end
    return b;
  endfunction

  // Sink taps back to word order; sr_po[0] is the stage next to sr_so.
  function automatic logic [WIDTH-1:0] readback(input logic [WIDTH-2:0] po, input logic so);
    logic [WIDTH-1:0] r;
    r = '0;
    if (MSB_FIRST != 0) begin
      r[WIDTH-1] = so;
      for (int i = 0; i < WIDTH - 1; i++) r[i] = po[WIDTH-2-i];
    end else begin
      r[0] = so;
      for (int i = 1; i < WIDTH; i++) r[i] = po[i-1];
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    end_of_bit = 1'b0;
    readback_w = readback(sr_po, sr_so);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shadow_d  = in_data;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: begin
        if (SETTLE > 0) begin
          state_d  = ST_SETTLE;
          settle_d = SW'(SLD);
        end else begin
          end_of_bit = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) end_of_bit = 1'b1;
        else                settle_d   = settle_q - 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // After the last pulse has settled the first bit sits at sr_so, so capture now.
    if (end_of_bit) begin
      if (bit_cnt_q == LAST_BIT) begin
        state_d    = ST_DONE;
        out_data_d = readback_w;
        out_err_d  = (readback_w != shadow_q);
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = ST_SETUP;
      end
    end

    sr_clk_d = (state_d == ST_PULSE);
    sr_si_d  = ((state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_SETTLE))
               ? bit_of(shadow_d, bit_cnt_d) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      settle_q   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_si_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      settle_q   <= settle_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      sr_clk_q   <= sr_clk_d;
      sr_si_q    <= sr_si_d;
    end
  end

  // The shadow word is only meaningful after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign sr_clk    = sr_clk_q;
  assign sr_si     = sr_si_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Bench for shiftreg_seq: two configurations driving behavioural shift-register sinks,
// with directed and randomized words checked against a word-level reference.
module tb_shiftreg_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_sr_si, a_sr_clk, a_out_valid, a_out_err, a_busy, a_so;
  logic [W-1:0] a_out_data, a_stg, a_stuck, a_obs;
  logic [W-2:0] a_po;
  logic         b_in_ready, b_sr_si, b_sr_clk, b_out_valid, b_out_err, b_busy, b_so;
  logic [W-1:0] b_out_data, b_stg, b_stuck, b_obs;
  logic [W-2:0] b_po;

  shiftreg_seq #(.WIDTH(W), .SETTLE(2), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .sr_si(a_sr_si), .sr_clk(a_sr_clk), .sr_po(a_po), .sr_so(a_so),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_err(a_out_err), .busy(a_busy));

  shiftreg_seq #(.WIDTH(W), .SETTLE(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .sr_si(b_sr_si), .sr_clk(b_sr_clk), .sr_po(b_po), .sr_so(b_so),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_err(b_out_err), .busy(b_busy));

  // Behavioural sinks: stage 0 takes si on each pulse; so is the last stage; po[0] is next to so.
  always @(posedge a_sr_clk) a_stg <= {a_stg[W-2:0], a_sr_si};
  always @(posedge b_sr_clk) b_stg <= {b_stg[W-2:0], b_sr_si};
  assign a_obs = a_stg & ~a_stuck;
  assign b_obs = b_stg & ~b_stuck;
  assign a_so  = a_obs[W-1];
  assign b_so  = b_obs[W-1];
  always_comb begin
    a_po = '0;
    b_po = '0;
    for (int m = 0; m < W - 1; m++) begin
      a_po[m] = a_obs[W-2-m];
      b_po[m] = b_obs[W-2-m];
    end
  end

  // Observed configuration
  logic         m_in_ready, m_sr_si, m_sr_clk, m_out_valid, m_out_err, m_busy;
  logic [W-1:0] m_out_data;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_sr_si     = sel ? b_sr_si     : a_sr_si;
  assign m_sr_clk    = sel ? b_sr_clk    : a_sr_clk;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_err   = sel ? b_out_err   : a_out_err;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_out_data  = sel ? b_out_data  : a_out_data;

  int checks = 0;
  int errors = 0;
  int s_cur  = 2;
  bit msb_cur = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A healthy register returns the word; a stuck stage clears the word bit it holds.
  function automatic logic [W-1:0] exp_out(input logic [W-1:0] w, input logic [W-1:0] st,
                                           input bit msb);
    logic [W-1:0] r;
    r = w;
    for (int j = 0; j < W; j++) if (st[j]) r[msb ? j : W-1-j] = 1'b0;
    return r;
  endfunction

  task automatic run_word(input logic [W-1:0] w, input int rdy_dly, input bit poke);
    int p, lat, npulse, clk_bad, si_bad, hold_bad, c;
    logic [W-1:0] expo, d0, st;
    logic e0, bk;
    p = 2 + s_cur;
    st = sel ? b_stuck : a_stuck;
    c = 0;
    while (!m_in_ready && c < 200) begin @(negedge clk); c++; end
    chk("idle_before", m_in_ready, 1);
    in_valid = 1'b1; in_data = w; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = W'($urandom);
    lat = -1; npulse = 0; clk_bad = 0; si_bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_out_valid) begin lat = k; break; end
      if (m_sr_clk !== ((k % p) == 1)) clk_bad++;
      if (m_sr_clk === 1'b1) npulse++;
      if (k / p < W) begin
        bk = msb_cur ? w[W-1-(k/p)] : w[k/p];
        if (m_sr_si !== bk) si_bad++;
      end
      @(negedge clk);
    end
    chk("latency", lat, W * p);
    chk("pulses", npulse, W);
    chk("clk_shape", clk_bad, 0);
    chk("si_seq", si_bad, 0);
    expo = exp_out(w, st, msb_cur);
    chk("out_data", m_out_data, expo);
    chk("out_err", m_out_err, expo != w);
    chk("si_done", m_sr_si, 0);
    d0 = m_out_data; e0 = m_out_err; hold_bad = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      if (poke) begin in_valid = 1'b1; in_data = ~w; end
      @(negedge clk);
      if (m_out_data !== d0 || m_out_err !== e0 || m_in_ready !== 1'b0 || m_out_valid !== 1'b1)
        hold_bad++;
    end
    chk("hold", hold_bad, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", m_out_valid, 0);
    chk("release_idle", m_busy, 0);
  endtask

  task automatic do_reset(input bit s);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    sel = s; s_cur = s ? 0 : 2; msb_cur = !s;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c, c_ov, c_rdy, lat2, seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0;
    a_stuck = '0; b_stuck = '0;
    repeat (3) @(negedge clk);
    chk("rst_sr_clk", m_sr_clk, 0);
    chk("rst_sr_si", m_sr_si, 0);
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_out_err", m_out_err, 0);
    chk("rst_out_data", m_out_data, 0);
    chk("rst_busy", m_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", m_in_ready, 1);

    run_word(8'hA5, 0, 1'b0);
    run_word(8'h5A, 10, 1'b1);
    a_stuck = 8'h08;
    run_word(8'hFF, 2, 1'b0);
    a_stuck = '0;

    // Abort mid-shift while a pulse is high
    in_valid = 1'b1; in_data = 8'h96;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("mid_pulse", m_sr_clk, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sr_clk", m_sr_clk, 0);
    chk("abort_out_valid", m_out_valid, 0);
    chk("abort_busy", m_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", m_in_ready, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (m_out_valid) seen++; end
    chk("abort_no_out", seen, 0);

    for (int n = 0; n < 12; n++) begin
      a_stuck = ($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      run_word(W'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    a_stuck = '0;

    // Back-to-back with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_data = 8'hC3;
    c_ov = -1; c_rdy = -1;
    for (c = 0; c < 200; c++) begin
      if (c_ov < 0 && m_out_valid) begin
        c_ov = c;
        chk("b2b_data0", m_out_data, 8'h3C);
        chk("b2b_err0", m_out_err, 0);
      end
      if (c_ov >= 0 && m_in_ready) begin c_rdy = c; break; end
      @(negedge clk);
    end
    chk("b2b_lat0", c_ov, 32);
    chk("b2b_gap", c_rdy + 1 - c_ov, 2);
    @(negedge clk);
    in_valid = 1'b0;
    lat2 = -1;
    for (c = 0; c < 200; c++) begin
      if (m_out_valid) begin lat2 = c; break; end
      @(negedge clk);
    end
    chk("b2b_lat1", lat2, 32);
    chk("b2b_data1", m_out_data, 8'hC3);
    chk("b2b_err1", m_out_err, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", m_busy, 0);

    do_reset(1'b1);
    run_word(8'h01, 0, 1'b0);
    b_stuck = 8'h08;
    run_word(8'hFF, 1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      b_stuck = ($urandom_range(0, 3) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      run_word(W'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
